// File: rtl/aq_djpeg_pkg.sv
// Shared definitions for the zigzag de-scan block buffer: the JPEG
// zigzag-to-natural index table, the component colour tag type and a
// helper that converts a row-major natural index to column-major.
package aq_djpeg_pkg;

  // Component tag carried alongside each committed block
  typedef logic [2:0] color_t;

  // Zigzag scan position -> natural (row*8+col) coefficient index
  localparam logic [5:0] ZZ2NAT [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Swap row and column fields: row*8+col becomes col*8+row
  function automatic logic [5:0] transpose_idx(input logic [5:0] idx);
    return {idx[2:0], idx[5:3]};
  endfunction

endpackage

// File: rtl/aq_djpeg_zz_map.sv
// Combinational zigzag-to-natural lookup.
// Build option: AQ_DJPEG_ZZ_TRANSPOSE_EN selects column-major natural
// order (col*8+row); otherwise row-major (row*8+col).
module aq_djpeg_zz_map
  import aq_djpeg_pkg::*;
(
  input  logic [5:0] zz,
  output logic [5:0] nat
);

  // Table lookup, optionally transposed
  always_comb begin
    nat = 6'd0;
`ifdef AQ_DJPEG_ZZ_TRANSPOSE_EN
    nat = transpose_idx(ZZ2NAT[zz]);
`else
    nat = ZZ2NAT[zz];
`endif
  end

endmodule

// File: rtl/aq_djpeg_zigzag_nbank.sv
// Multi-bank zigzag de-scan buffer. Coefficients arrive in zigzag order and
// are stored at their natural index; committed blocks are read back as
// pairs (index r from the low RAM, index r+32 from the high RAM).
// Entries never written in a block read as zero via per-entry present bits.
// Build option: AQ_DJPEG_ZZ_TRANSPOSE_EN (column-major natural order).
module aq_djpeg_zigzag_nbank
  import aq_djpeg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int BANKS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              in_valid,
  input  logic [5:0]        in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [2:0]        in_color,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_rd,
  input  logic [4:0]        out_addr,
  output logic [2:0]        out_color,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              overflow
);

  localparam int PTR_W = $clog2(BANKS);
  localparam int CNT_W = $clog2(BANKS + 1);
  localparam int DEPTH = BANKS * 32;

  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic [BANKS-1:0][63:0] present_r;
  color_t                 color_r [BANKS];
  logic                   overflow_r;
  logic                   pres_a_r;
  logic                   pres_b_r;
  logic [DATA_W-1:0]      q_lo_r;
  logic [DATA_W-1:0]      q_hi_r;
  logic [DATA_W-1:0]      ram_lo [DEPTH];
  logic [DATA_W-1:0]      ram_hi [DEPTH];

  logic       flush_s;
  logic       full_s;
  logic       wr_en_s;
  logic       commit_s;
  logic       rd_en_s;
  logic       rel_s;
  logic [5:0] nat_s;

  aq_djpeg_zz_map u_zz_map (
    .zz  (in_addr),
    .nat (nat_s)
  );

  assign flush_s   = rst | init;
  assign full_s    = (count_r == CNT_W'(BANKS));
  assign in_ready  = ~full_s;
  assign out_valid = (count_r != {CNT_W{1'b0}});
  // Read and write banks always differ while both may be active: a read
  // needs count > 0 and a write needs count < BANKS.
  assign wr_en_s   = in_valid & ~full_s & ~flush_s;
  assign commit_s  = in_last  & ~full_s & ~flush_s;
  assign rd_en_s   = out_rd & out_valid & ~flush_s;
  assign rel_s     = rd_en_s & (out_addr == 5'd31);

  assign out_color = color_r[rd_ptr_r];
  assign out_a     = pres_a_r ? q_lo_r : {DATA_W{1'b0}};
  assign out_b     = pres_b_r ? q_hi_r : {DATA_W{1'b0}};
  assign overflow  = overflow_r;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (flush_s) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (commit_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (rel_s)    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({commit_s, rel_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Present bits: set per write, cleared bank-wide on release
  always_ff @(posedge clk) begin
    if (flush_s) begin
      present_r <= '0;
    end else begin
      if (rel_s)   present_r[rd_ptr_r] <= 64'd0;
      if (wr_en_s) present_r[wr_ptr_r][nat_s] <= 1'b1;
    end
  end

  // Colour tag per bank, captured at commit
  always_ff @(posedge clk) begin
    if (flush_s) begin
      for (int b = 0; b < BANKS; b++) color_r[b] <= 3'd0;
    end else if (commit_s) begin
      color_r[wr_ptr_r] <= in_color;
    end
  end

  // Sticky overflow on any write or commit attempt into a full buffer
  always_ff @(posedge clk) begin
    if (flush_s) begin
      overflow_r <= 1'b0;
    end else if ((in_valid | in_last) & full_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Present-bit snapshot for the pair being read; zero masks the RAM data
  always_ff @(posedge clk) begin
    if (flush_s) begin
      pres_a_r <= 1'b0;
      pres_b_r <= 1'b0;
    end else if (rd_en_s) begin
      pres_a_r <= present_r[rd_ptr_r][{1'b0, out_addr}];
      pres_b_r <= present_r[rd_ptr_r][{1'b1, out_addr}];
    end
  end

  // Low RAM (natural rows 0-3): write port and synchronous read
  always_ff @(posedge clk) begin
    if (wr_en_s && !nat_s[5]) ram_lo[{wr_ptr_r, nat_s[4:0]}] <= in_data;
    if (rd_en_s) q_lo_r <= ram_lo[{rd_ptr_r, out_addr}];
  end

  // High RAM (natural rows 4-7): write port and synchronous read
  always_ff @(posedge clk) begin
    if (wr_en_s && nat_s[5]) ram_hi[{wr_ptr_r, nat_s[4:0]}] <= in_data;
    if (rd_en_s) q_hi_r <= ram_hi[{rd_ptr_r, out_addr}];
  end

endmodule

// File: doc/aq_djpeg_zigzag_nbank.md
AQ_DJPEG_ZIGZAG_NBANK -- requirements
Module: aq_djpeg_zigzag_nbank

Interface
REQ-001 Parameter DATA_W, default 16: coefficient width in bits.
REQ-002 Parameter BANKS, default 4: number of 64-coefficient block banks; power of two, 2..16.
REQ-003 Port clk  input  1: single clock; all logic on the rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port init  input  1: synchronous flush of all state.
REQ-006 Port in_valid  input  1: coefficient write strobe.
REQ-007 Port in_addr  input  6: zigzag index 0..63.
REQ-008 Port in_data  input  DATA_W: coefficient value.
REQ-009 Port in_last  input  1: commits the current write bank.
REQ-010 Port in_color  input  3: component tag, captured on in_last.
REQ-011 Port in_ready  output  1: high when a bank is free for writing (count < BANKS).
REQ-012 Port out_valid  output  1: high when at least one committed bank exists (count > 0).
REQ-013 Port out_rd  input  1: read strobe.
REQ-014 Port out_addr  input  5: read pair index r, 0..31.
REQ-015 Port out_color  output  3: tag of the current read bank.
REQ-016 Port out_a  output  DATA_W: natural-order coefficient at index r.
REQ-017 Port out_b  output  DATA_W: natural-order coefficient at index r+32.
REQ-018 Port overflow  output  1: sticky; set by a write or commit while count == BANKS.

Function
REQ-019 Write pointer, read pointer and occupancy count (0..BANKS) SHALL be maintained, with both pointers wrapping modulo BANKS.
REQ-020 A write with in_valid and in_ready SHALL store in_data at natural index zz2nat(in_addr) of the write bank and set that entry's present bit.
REQ-021 A write while count == BANKS SHALL be dropped and SHALL set overflow.
REQ-022 in_last with in_ready SHALL latch in_color to the write bank, advance the write pointer and increment the count.
REQ-023 in_valid and in_last in the same cycle: the write SHALL land in the bank being committed.
REQ-024 out_rd SHALL be honoured only while out_valid is high; out_rd while out_valid is low SHALL be ignored.
REQ-025 A read issued in cycle N SHALL present out_a/out_b in cycle N+1 (1-cycle latency); outputs SHALL hold between reads.
REQ-026 An entry whose present bit is clear SHALL read as 0.
REQ-027 out_rd with out_addr == 31 SHALL release the bank: clear all 64 of its present bits, advance the read pointer, decrement the count.
REQ-028 Commit and release in the same cycle SHALL leave the count unchanged; both pointers SHALL advance.
REQ-029 Write-pointer wrap SHALL be seamless (BANKS-1 -> 0) with no lost cycle.
REQ-030 init SHALL take priority over every other input: pointers, count, present bits and overflow SHALL be zeroed in one cycle, with in_ready = 1 on the next cycle.
REQ-031 out_color SHALL be combinational from the read pointer.

Reset
REQ-032 rst SHALL produce the same state as init.
REQ-033 After rst: in_ready = 1, out_valid = 0, overflow = 0, out_a = out_b = 0, out_color = 0.
REQ-034 Coefficient RAM contents need not be reset; the present bits mask them.
REQ-035 rst mid-block SHALL discard any partial bank.

Configuration
REQ-036 With AQ_DJPEG_ZZ_TRANSPOSE_EN defined, natural index SHALL be col*8+row, so out_a/out_b deliver column pairs.
REQ-037 Without AQ_DJPEG_ZZ_TRANSPOSE_EN, natural index SHALL be row*8+col.

Structure
REQ-038 Package aq_djpeg_pkg SHALL hold the zigzag-to-natural table (64 x 6 bits) and the color tag type.
REQ-039 Sub-module aq_djpeg_zz_map SHALL be the combinational zz2nat lookup, honouring the transpose macro.
REQ-040 Storage SHALL be two RAMs (rows 0-3, rows 4-7), each BANKS*32 x DATA_W, with synchronous read.

Verification
REQ-041 Write zz 0..63 with value = zz+1, in_last, color 2; read r = 0..31 -> out_a[0] = 1, out_a[1] = 2, out_a[8] = 3, out_b[31] (index 63) = 64, out_color = 2.
REQ-042 Sparse block: only zz 0 = 100; read -> out_a[0] = 100, all others 0; then a full block in the same bank after wrap -> no stale data.
REQ-043 Commit BANKS blocks with no reads -> in_ready = 0; a further write raises overflow; one 32-read release -> in_ready = 1, overflow stays 1.
REQ-044 Commit and out_addr = 31 release in the same cycle at count 2 -> count stays 2, both pointers +1.
REQ-045 init mid-block with count 3 -> next cycle out_valid = 0, in_ready = 1, overflow = 0.
REQ-046 Transpose build: zz 1 (row 0, col 1) = 7 -> appears at out_a[8], not out_a[1].
